// File: rtl/compute_disp_row.sv
// Row disparity engine: for each window column of a WIN-row stereo strip, searches
// candidate disparities one per cycle by SAD and emits the best match with a valid/ready handshake.
module compute_disp_row #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 64,
  parameter int MAX_DISP  = 64,
  localparam int DISP_BITS  = $clog2(MAX_DISP),
  localparam int SAD_BITS   = $clog2(WIN*WIN*((1 << DATA_SIZE) - 1) + 1),
  localparam int COL_BITS   = $clog2(IMG_W),
  localparam int STRIP_BITS = DATA_SIZE*IMG_W*WIN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [STRIP_BITS-1:0] input_array_L,
  input  logic [STRIP_BITS-1:0] input_array_R,
  input  logic [COL_BITS-1:0]   col_start,
  input  logic [COL_BITS-1:0]   col_end,
  input  logic [DISP_BITS-1:0]  disp_limit,
  input  logic [SAD_BITS-1:0]   sad_thresh,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DISP_BITS-1:0]  out_disp,
  output logic [SAD_BITS-1:0]   out_sad,
  output logic [COL_BITS-1:0]   out_col,
  output logic                  out_conf,
  output logic                  done,
  output logic                  err
);

  localparam int IDX_BITS = $clog2(STRIP_BITS);

  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, EMIT, FINISH} state_t;

  state_t                state_q, state_d;
  logic [STRIP_BITS-1:0] strip_l_q, strip_l_d, strip_r_q, strip_r_d;
  logic [COL_BITS-1:0]   col_q, col_d, col_end_q, col_end_d;
  logic [DISP_BITS-1:0]  disp_q, disp_d, dlim_q, dlim_d;
  logic [SAD_BITS-1:0]   thresh_q, thresh_d;
  logic [SAD_BITS-1:0]   best_sad_q, best_sad_d;
  logic [DISP_BITS-1:0]  best_disp_q, best_disp_d;
  logic                  busy_q, busy_d, out_valid_q, out_valid_d;
  logic [DISP_BITS-1:0]  out_disp_q, out_disp_d;
  logic [SAD_BITS-1:0]   out_sad_q, out_sad_d;
  logic [COL_BITS-1:0]   out_col_q, out_col_d;
  logic                  out_conf_q, out_conf_d, done_q, done_d, err_q, err_d;

  logic [SAD_BITS-1:0]   sad_cur, cand_sad;
  logic [DISP_BITS-1:0]  dmax, cand_disp;
  logic [DATA_SIZE-1:0]  pix_l, pix_r, pix_abs;
  logic [IDX_BITS-1:0]   idx_l, idx_r;
  int                    lim_i;

  // Window SAD for the current (column, disparity); right-strip column is c+k-d >= 0 since d <= c.
  always_comb begin
    sad_cur = '0;
    pix_l   = '0;
    pix_r   = '0;
    pix_abs = '0;
    idx_l   = '0;
    idx_r   = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int k = 0; k < WIN; k++) begin
        idx_l   = IDX_BITS'((r*IMG_W + int'(col_q) + k) * DATA_SIZE);
        idx_r   = IDX_BITS'((r*IMG_W + int'(col_q) + k - int'(disp_q)) * DATA_SIZE);
        pix_l   = strip_l_q[idx_l +: DATA_SIZE];
        pix_r   = strip_r_q[idx_r +: DATA_SIZE];
        pix_abs = (pix_l >= pix_r) ? (pix_l - pix_r) : (pix_r - pix_l);
        sad_cur = sad_cur + SAD_BITS'(pix_abs);
      end
    end
  end

  always_comb begin
    lim_i = int'(dlim_q);
    if (int'(col_q) < lim_i) lim_i = int'(col_q);
    if (lim_i > MAX_DISP - 1) lim_i = MAX_DISP - 1;
    dmax = DISP_BITS'(lim_i);
    // Strict compare keeps the lowest disparity on ties.
    cand_sad  = (sad_cur < best_sad_q) ? sad_cur : best_sad_q;
    cand_disp = (sad_cur < best_sad_q) ? disp_q  : best_disp_q;
  end

  always_comb begin
    state_d     = state_q;
    strip_l_d   = strip_l_q;
    strip_r_d   = strip_r_q;
    col_d       = col_q;
    col_end_d   = col_end_q;
    disp_d      = disp_q;
    dlim_d      = dlim_q;
    thresh_d    = thresh_q;
    best_sad_d  = best_sad_q;
    best_disp_d = best_disp_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_disp_d  = out_disp_q;
    out_sad_d   = out_sad_q;
    out_col_d   = out_col_q;
    out_conf_d  = out_conf_q;
    done_d      = done_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        strip_l_d   = input_array_L;
        strip_r_d   = input_array_R;
        col_end_d   = col_end;
        dlim_d      = disp_limit;
        thresh_d    = sad_thresh;
        col_d       = col_start;
        disp_d      = '0;
        best_sad_d  = '1;
        best_disp_d = '0;
        if (col_start > col_end || int'(col_end) > IMG_W - WIN) begin
          state_d = FINISH;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        best_sad_d  = cand_sad;
        best_disp_d = cand_disp;
        if (disp_q == dmax) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_sad_d   = cand_sad;
          out_disp_d  = cand_disp;
          out_col_d   = col_q;
          out_conf_d  = (cand_sad <= thresh_q);
        end else begin
          disp_d = disp_q + 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (col_q < col_end_q) begin
            col_d       = col_q + 1'b1;
            disp_d      = '0;
            best_sad_d  = '1;
            best_disp_d = '0;
            state_d     = SEARCH;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end
        end
      end
      FINISH: begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      strip_l_q   <= '0;
      strip_r_q   <= '0;
      col_q       <= '0;
      col_end_q   <= '0;
      disp_q      <= '0;
      dlim_q      <= '0;
      thresh_q    <= '0;
      best_sad_q  <= '0;
      best_disp_q <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_disp_q  <= '0;
      out_sad_q   <= '0;
      out_col_q   <= '0;
      out_conf_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      strip_l_q   <= strip_l_d;
      strip_r_q   <= strip_r_d;
      col_q       <= col_d;
      col_end_q   <= col_end_d;
      disp_q      <= disp_d;
      dlim_q      <= dlim_d;
      thresh_q    <= thresh_d;
      best_sad_q  <= best_sad_d;
      best_disp_q <= best_disp_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_disp_q  <= out_disp_d;
      out_sad_q   <= out_sad_d;
      out_col_q   <= out_col_d;
      out_conf_q  <= out_conf_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_disp  = out_disp_q;
  assign out_sad   = out_sad_q;
  assign out_col   = out_col_q;
  assign out_conf  = out_conf_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_compute_disp_row.sv
// Directed bench for compute_disp_row: hand-computed expectations for shifted, uniform,
// saturating, rejected, back-pressured and reset-aborted row jobs.
module tb_compute_disp_row;

  localparam int WIN        = 15;
  localparam int DATA_SIZE  = 8;
  localparam int IMG_W      = 64;
  localparam int MAX_DISP   = 64;
  localparam int DISP_BITS  = $clog2(MAX_DISP);
  localparam int SAD_BITS   = $clog2(WIN*WIN*((1 << DATA_SIZE) - 1) + 1);
  localparam int COL_BITS   = $clog2(IMG_W);
  localparam int STRIP_BITS = DATA_SIZE*IMG_W*WIN;
  localparam int IDX_BITS   = $clog2(STRIP_BITS);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [STRIP_BITS-1:0] in_l = '0;
  logic [STRIP_BITS-1:0] in_r = '0;
  logic [COL_BITS-1:0]   col_start = '0;
  logic [COL_BITS-1:0]   col_end = '0;
  logic [DISP_BITS-1:0]  disp_limit = '0;
  logic [SAD_BITS-1:0]   sad_thresh = '0;
  logic                  out_ready = 1'b1;
  logic                  busy, out_valid, out_conf, done, err;
  logic [DISP_BITS-1:0]  out_disp;
  logic [SAD_BITS-1:0]   out_sad;
  logic [COL_BITS-1:0]   out_col;

  int check_count = 0;
  int fail_count  = 0;
  int res_col[$];
  int res_disp[$];
  int res_sad[$];
  int res_conf[$];
  int first_valid, done_count, done_cyc, err_at_done;

  compute_disp_row #(
    .WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_array_L(in_l), .input_array_R(in_r),
    .col_start(col_start), .col_end(col_end),
    .disp_limit(disp_limit), .sad_thresh(sad_thresh),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_disp(out_disp), .out_sad(out_sad), .out_col(out_col),
    .out_conf(out_conf), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] hashPix(input int r, input int x);
    int v;
    v = x*x*7 + x*13 + r*29 + 5;
    return 8'(v);
  endfunction

  task automatic setPix(input bit right, input int r, input int c, input logic [7:0] v);
    logic [IDX_BITS-1:0] idx;
    idx = IDX_BITS'((r*IMG_W + c) * DATA_SIZE);
    if (right) in_r[idx +: DATA_SIZE] = v;
    else       in_l[idx +: DATA_SIZE] = v;
  endtask

  // Right strip holds the left content five pixels further left, so d=5 matches exactly.
  task automatic buildShift();
    for (int r = 0; r < WIN; r++) begin
      for (int x = 0; x < IMG_W; x++) begin
        setPix(1'b0, r, x, hashPix(r, x));
        setPix(1'b1, r, x, (x + 5 < IMG_W) ? hashPix(r, x + 5) : 8'h00);
      end
    end
  endtask

  task automatic buildUniform(input logic [7:0] lv, input logic [7:0] rv);
    for (int r = 0; r < WIN; r++) begin
      for (int x = 0; x < IMG_W; x++) begin
        setPix(1'b0, r, x, lv);
        setPix(1'b1, r, x, rv);
      end
    end
  endtask

  task automatic applyStimulus(input int cs, input int ce, input int dl, input int th);
    @(negedge clk);
    col_start  = COL_BITS'(cs);
    col_end    = COL_BITS'(ce);
    disp_limit = DISP_BITS'(dl);
    sad_thresh = SAD_BITS'(th);
    out_ready  = 1'b1;
    start      = 1'b1;
  endtask

  // Runs one job from the start cycle; inputs are scrambled once the LOAD cycle is over.
  task automatic runJob(input int stall, input int s_disp, input int s_sad, input int s_col);
    int  cyc;
    int  stall_left;
    bit  finished;
    res_col.delete(); res_disp.delete(); res_sad.delete(); res_conf.delete();
    first_valid = -1; done_count = 0; done_cyc = -1; err_at_done = -1;
    cyc = 0; finished = 1'b0; stall_left = stall;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 2) begin
        in_l = ~in_l;
        in_r = '0;
        col_start = '0;
        col_end = '1;
        disp_limit = '1;
        sad_thresh = ~sad_thresh;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        err_at_done = int'(err);
        finished = 1'b1;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          checkOutput("stall_valid", int'(out_valid), 1);
          checkOutput("stall_disp", int'(out_disp), s_disp);
          checkOutput("stall_sad", int'(out_sad), s_sad);
          checkOutput("stall_col", int'(out_col), s_col);
          stall_left--;
        end else begin
          out_ready = 1'b1;
          res_col.push_back(int'(out_col));
          res_disp.push_back(int'(out_disp));
          res_sad.push_back(int'(out_sad));
          res_conf.push_back(int'(out_conf));
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    checkOutput("job_terminates", int'(finished), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("done_once", done_count, 1);
    checkOutput("busy_after_job", int'(busy), 0);
  endtask

  task automatic checkShiftJob();
    checkOutput("shift_count", res_col.size(), 3);
    for (int i = 0; i < res_col.size() && i < 3; i++) begin
      checkOutput("shift_col", res_col[i], 10 + i);
      checkOutput("shift_disp", res_disp[i], 5);
      checkOutput("shift_sad", res_sad[i], 0);
      checkOutput("shift_conf", res_conf[i], 1);
    end
    checkOutput("shift_err", err_at_done, 0);
  endtask

  initial begin
    int  acc;
    bit  found;
    int  done_seen, busy_seen;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_disp", int'(out_disp), 0);
    checkOutput("rst_sad", int'(out_sad), 0);
    checkOutput("rst_col", int'(out_col), 0);
    checkOutput("rst_conf", int'(out_conf), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_release", int'(busy), 0);

    // Shifted strips, three columns
    buildShift();
    applyStimulus(10, 12, 20, 0);
    runJob(0, 0, 0, 0);
    checkShiftJob();
    checkOutput("shift_latency", first_valid, 13);

    // Uniform strips: tie keeps d=0, dmax=3 gives four search cycles
    buildUniform(8'h40, 8'h40);
    applyStimulus(3, 3, 10, 0);
    runJob(0, 0, 0, 0);
    checkOutput("uni_count", res_col.size(), 1);
    if (res_col.size() > 0) begin
      checkOutput("uni_disp", res_disp[0], 0);
      checkOutput("uni_sad", res_sad[0], 0);
      checkOutput("uni_col", res_col[0], 3);
    end
    checkOutput("uni_search_cycles", first_valid - 2, 4);
    checkOutput("uni_err", err_at_done, 0);

    // Rejected job: col_start > col_end
    applyStimulus(7, 5, 10, 0);
    runJob(0, 0, 0, 0);
    checkOutput("rej_no_valid", first_valid, -1);
    checkOutput("rej_done_cycle", done_cyc, 2);
    checkOutput("rej_err", err_at_done, 1);

    // Rejected job: col_end beyond the last full window
    applyStimulus(40, 50, 10, 0);
    runJob(0, 0, 0, 0);
    checkOutput("range_no_valid", first_valid, -1);
    checkOutput("range_err", err_at_done, 1);

    // Back-pressure for 20 cycles on a single result
    buildShift();
    applyStimulus(10, 10, 20, 0);
    runJob(20, 5, 0, 10);
    checkOutput("bp_count", res_col.size(), 1);
    if (res_col.size() > 0) begin
      checkOutput("bp_disp", res_disp[0], 5);
      checkOutput("bp_sad", res_sad[0], 0);
      checkOutput("bp_col", res_col[0], 10);
    end

    // Worst-case SAD at the last legal column with disp_limit=0
    buildUniform(8'hFF, 8'h00);
    applyStimulus(49, 49, 0, 1000);
    runJob(0, 0, 0, 0);
    checkOutput("max_count", res_col.size(), 1);
    if (res_col.size() > 0) begin
      checkOutput("max_sad", res_sad[0], 57375);
      checkOutput("max_conf", res_conf[0], 0);
      checkOutput("max_disp", res_disp[0], 0);
      checkOutput("max_col", res_col[0], 49);
    end

    // Threshold equal to SAD is confident
    buildUniform(8'hFF, 8'h00);
    applyStimulus(0, 0, 5, 57375);
    runJob(0, 0, 0, 0);
    checkOutput("eq_count", res_col.size(), 1);
    if (res_col.size() > 0) checkOutput("eq_conf", res_conf[0], 1);

    // Reset during the second column's search
    buildShift();
    applyStimulus(10, 12, 20, 0);
    acc = 0;
    found = 1'b0;
    for (int cyc = 1; cyc < 200 && !found; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      out_ready = 1'b1;
      if (out_valid) acc++;
      else if (acc == 1 && busy) found = 1'b1;
    end
    checkOutput("rst_reach_col2", int'(found), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_valid", int'(out_valid), 0);
    checkOutput("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy || out_valid) busy_seen++;
    end
    checkOutput("postrst_no_done", done_seen, 0);
    checkOutput("postrst_idle", busy_seen, 0);

    buildShift();
    applyStimulus(10, 12, 20, 0);
    runJob(0, 0, 0, 0);
    checkShiftJob();

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
